// File: rtl/blake2_input_driver.sv
// Blake2 input-stream driver: serialises parameter sets and 512-bit
// message blocks into the byte-wide valid/cmd/data command stream.
module blake2_input_driver #(
    parameter int BLOCK_BYTES = 64,
    parameter int CFG_BYTES   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_v_i,
    output logic                     cfg_ready_o,
    input  logic [7:0]               kk_i,
    input  logic [7:0]               nn_i,
    input  logic [7:0]               ll_i,
    input  logic                     block_v_i,
    output logic                     block_ready_o,
    input  logic [8*BLOCK_BYTES-1:0] block_i,
    input  logic                     block_first_i,
    input  logic                     block_last_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [1:0]               cmd_o,
    output logic [7:0]               data_o,
    output logic                     msg_done_o,
    output logic                     busy_o
);

    localparam int CW = $clog2(BLOCK_BYTES);
    localparam int SW = 8 * BLOCK_BYTES;

    localparam logic [1:0] CMD_CONF  = 2'd0;
    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_DATA  = 2'd2;
    localparam logic [1:0] CMD_LAST  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CFG  = 2'd1,
        S_BLK  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [SW-1:0]   sh_q;
    logic            first_q;
    logic            last_q;
    logic            in_msg_q;
    logic            msg_done_q;

    logic            cfg_acc;
    logic            blk_acc;
    logic            xfer;
    logic            cfg_end;
    logic            blk_end;

    assign cfg_ready_o   = (state_q == S_IDLE) & ~in_msg_q;
    assign block_ready_o = (state_q == S_IDLE) & ~(cfg_v_i & cfg_ready_o);

    assign cfg_acc = cfg_v_i & cfg_ready_o;
    assign blk_acc = block_v_i & block_ready_o;
    assign xfer    = valid_o & ready_i;
    assign cfg_end = cnt_q == CW'(CFG_BYTES - 1);
    assign blk_end = cnt_q == CW'(BLOCK_BYTES - 1);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave IDLE on an accept, return after the final byte.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_acc) begin
                    state_d = S_CFG;
                end else if (blk_acc) begin
                    state_d = S_BLK;
                end
            end
            S_CFG: begin
                if (xfer && cfg_end) begin
                    state_d = S_IDLE;
                end
            end
            S_BLK: begin
                if (xfer && blk_end) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shift register, byte counter and message tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q       <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            in_msg_q   <= 1'b0;
            msg_done_q <= 1'b0;
        end else begin
            msg_done_q <= xfer & (state_q == S_BLK) & blk_end & last_q;
            if (cfg_acc) begin
                sh_q  <= {{(SW - 24){1'b0}}, ll_i, nn_i, kk_i};
                cnt_q <= '0;
            end else if (blk_acc) begin
                sh_q    <= block_i;
                cnt_q   <= '0;
                first_q <= block_first_i;
                last_q  <= block_last_i;
                if (block_first_i) begin
                    in_msg_q <= 1'b1;
                end
            end else if (xfer) begin
                sh_q  <= sh_q >> 8;
                cnt_q <= cnt_q + CW'(1);
                if ((state_q == S_BLK) && blk_end && last_q) begin
                    in_msg_q <= 1'b0;
                end
            end
        end
    end

    // Stream outputs decoded from the registered state and counter.
    always_comb begin
        valid_o    = 1'b0;
        busy_o     = 1'b0;
        cmd_o      = CMD_CONF;
        data_o     = 8'h00;
        msg_done_o = msg_done_q;
        unique case (state_q)
            S_IDLE: begin
                valid_o = 1'b0;
            end
            S_CFG: begin
                valid_o = 1'b1;
                busy_o  = 1'b1;
                cmd_o   = CMD_CONF;
                data_o  = sh_q[7:0];
            end
            S_BLK: begin
                valid_o = 1'b1;
                busy_o  = 1'b1;
                data_o  = sh_q[7:0];
                if ((cnt_q == '0) && first_q) begin
                    cmd_o = CMD_START;
                end else if (blk_end && last_q) begin
                    cmd_o = CMD_LAST;
                end else begin
                    cmd_o = CMD_DATA;
                end
            end
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_blake2_input_driver.sv
// Directed bench for blake2_input_driver: config, blocks, message framing,
// backpressure, config/block priority and mid-block reset.
module tb_blake2_input_driver;

    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_v_i;
    logic         cfg_ready_o;
    logic [7:0]   kk_i;
    logic [7:0]   nn_i;
    logic [7:0]   ll_i;
    logic         block_v_i;
    logic         block_ready_o;
    logic [511:0] block_i;
    logic         block_first_i;
    logic         block_last_i;
    logic         valid_o;
    logic         ready_i;
    logic [1:0]   cmd_o;
    logic [7:0]   data_o;
    logic         msg_done_o;
    logic         busy_o;

    blake2_input_driver dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_v_i       (cfg_v_i),
        .cfg_ready_o   (cfg_ready_o),
        .kk_i          (kk_i),
        .nn_i          (nn_i),
        .ll_i          (ll_i),
        .block_v_i     (block_v_i),
        .block_ready_o (block_ready_o),
        .block_i       (block_i),
        .block_first_i (block_first_i),
        .block_last_i  (block_last_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .cmd_o         (cmd_o),
        .data_o        (data_o),
        .msg_done_o    (msg_done_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int nfail  = 0;

    // stream monitor state
    int         cyc = 0;
    logic [1:0] q_cmd[$];
    logic [7:0] q_dat[$];
    int         q_cyc[$];
    logic       pend = 1'b0;
    logic [1:0] h_cmd = 2'd0;
    logic [7:0] h_dat = 8'd0;
    int         stalls = 0;
    int         stall_bad = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         rdy_bad = 0;
    logic       watch = 1'b0;
    int         done_base = 0;

    // ready driver
    logic       bp_en = 1'b0;
    int         stall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!bp_en) begin
            ready_i <= 1'b1;
            stall   <= 0;
        end else if (stall != 0) begin
            ready_i <= 1'b0;
            stall   <= stall - 1;
        end else if ($urandom_range(0, 2) == 0) begin
            ready_i <= 1'b0;
            stall   <= int'($urandom_range(0, 4));
        end else begin
            ready_i <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                stalls <= stalls + 1;
                if (!valid_o || cmd_o !== h_cmd || data_o !== h_dat)
                    stall_bad <= stall_bad + 1;
            end
            pend  <= valid_o & ~ready_i;
            h_cmd <= cmd_o;
            h_dat <= data_o;
            if (valid_o && ready_i) begin
                q_cmd.push_back(cmd_o);
                q_dat.push_back(data_o);
                q_cyc.push_back(cyc);
            end
            if (msg_done_o) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (watch && done_cnt == done_base && !msg_done_o && cfg_ready_o)
                rdy_bad <= rdy_bad + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mkblk(input int base, input int step);
        logic [511:0] b;
        for (int k = 0; k < 64; k++) b[8*k +: 8] = 8'(base + step * k);
        return b;
    endfunction

    function automatic logic [1:0] ecmd(input int k, input bit f, input bit l);
        if (k == 0 && f) return 2'd1;
        if (k == 63 && l) return 2'd3;
        return 2'd2;
    endfunction

    task automatic send_cfg(input logic [7:0] k, input logic [7:0] n,
                            input logic [7:0] l);
        bit acc = 0;
        cfg_v_i = 1'b1;
        kk_i = k;
        nn_i = n;
        ll_i = l;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk);
            acc = cfg_ready_o;
            @(posedge clk);
            #1;
        end
        cfg_v_i = 1'b0;
        check("cfg_accept", 32'(acc), 32'd1);
    endtask

    task automatic send_block(input string tag, input logic [511:0] d,
                              input bit f, input bit l, input bit hold);
        bit acc = 0;
        block_v_i = 1'b1;
        block_i = d;
        block_first_i = f;
        block_last_i = l;
        for (int i = 0; i < 1000 && !acc; i++) begin
            @(negedge clk);
            acc = block_ready_o;
            @(posedge clk);
            #1;
        end
        if (!hold) block_v_i = 1'b0;
        check({tag, "_accept"}, 32'(acc), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            ok = !busy_o;
        end
        @(posedge clk);
        #1;
        check({tag, "_idle"}, 32'(ok), 32'd1);
    endtask

    task automatic check_blk(input string tag, input int qb, input int off,
                             input int base, input int step,
                             input bit f, input bit l);
        int nbad = 0;
        for (int k = 0; k < 64; k++) begin
            int idx = qb + off + k;
            logic [7:0] e = 8'(base + step * k);
            if (idx >= q_dat.size()) nbad++;
            else if (q_dat[idx] !== e || q_cmd[idx] !== ecmd(k, f, l)) nbad++;
        end
        check({tag, "_bytes"}, 32'(nbad), 32'd0);
    endtask

    initial begin
        int qb;
        int db;
        int s0;
        bit acc;
        reset = 1'b1;
        cfg_v_i = 1'b0;
        kk_i = 8'h00;
        nn_i = 8'h00;
        ll_i = 8'h00;
        block_v_i = 1'b0;
        block_i = '0;
        block_first_i = 1'b0;
        block_last_i = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_cmd", 32'(cmd_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_done", 32'(msg_done_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_cfg_rdy", 32'(cfg_ready_o), 32'd1);
        check("rst_blk_rdy", 32'(block_ready_o), 32'd1);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // config only
        send_cfg(8'h00, 8'h40, 8'h03);
        @(negedge clk);
        check("cfg_b0", {cmd_o, data_o, 7'd0, valid_o}, {2'd0, 8'h00, 7'd0, 1'b1});
        @(negedge clk);
        check("cfg_b1", {cmd_o, data_o, 7'd0, valid_o}, {2'd0, 8'h40, 7'd0, 1'b1});
        @(negedge clk);
        check("cfg_b2", {cmd_o, data_o, 7'd0, valid_o}, {2'd0, 8'h03, 7'd0, 1'b1});
        @(negedge clk);
        check("cfg_c4_busy", 32'(busy_o), 32'd0);
        check("cfg_c4_valid", 32'(valid_o), 32'd0);
        check("cfg_c4_rdy", 32'(cfg_ready_o), 32'd1);
        @(posedge clk);
        #1;

        // single first+last block, byte k = k
        qb = q_dat.size();
        db = done_cnt;
        send_block("blk1", mkblk(0, 1), 1'b1, 1'b1, 1'b0);
        wait_idle("blk1");
        check("blk1_count", 32'(q_dat.size() - qb), 32'd64);
        check_blk("blk1", qb, 0, 0, 1, 1'b1, 1'b1);
        check("blk1_done_cnt", 32'(done_cnt - db), 32'd1);
        if (q_cyc.size() >= qb + 64)
            check("blk1_done_cyc", 32'(done_cyc - q_cyc[qb+63]), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // three-block message, block_v held high
        qb = q_dat.size();
        db = done_cnt;
        send_block("m0", mkblk(8'h00, 1), 1'b1, 1'b0, 1'b1);
        done_base = done_cnt;
        watch = 1'b1;
        send_block("m1", mkblk(8'h40, 1), 1'b0, 1'b0, 1'b1);
        send_block("m2", mkblk(8'h80, 1), 1'b0, 1'b1, 1'b0);
        wait_idle("msg");
        watch = 1'b0;
        check("msg_count", 32'(q_dat.size() - qb), 32'd192);
        check_blk("msg_b0", qb, 0, 8'h00, 1, 1'b1, 1'b0);
        check_blk("msg_b1", qb, 64, 8'h40, 1, 1'b0, 1'b0);
        check_blk("msg_b2", qb, 128, 8'h80, 1, 1'b0, 1'b1);
        check("msg_cfg_rdy_low", 32'(rdy_bad), 32'd0);
        check("msg_done_cnt", 32'(done_cnt - db), 32'd1);
        if (q_cyc.size() >= qb + 192) begin
            check("msg_gap01", 32'(q_cyc[qb+64] - q_cyc[qb+63]), 32'd2);
            check("msg_gap12", 32'(q_cyc[qb+128] - q_cyc[qb+127]), 32'd2);
            check("msg_done_cyc", 32'(done_cyc - q_cyc[qb+191]), 32'd1);
        end
        repeat (2) @(posedge clk);
        #1;

        // backpressure
        bp_en = 1'b1;
        s0 = stalls;
        qb = q_dat.size();
        send_block("bp", mkblk(8'h11, 3), 1'b1, 1'b1, 1'b0);
        wait_idle("bp");
        bp_en = 1'b0;
        check("bp_count", 32'(q_dat.size() - qb), 32'd64);
        check_blk("bp", qb, 0, 8'h11, 3, 1'b1, 1'b1);
        check("bp_stalled", 32'(stalls > s0), 32'd1);
        check("bp_stable", 32'(stall_bad), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // config and block offered together
        qb = q_dat.size();
        cfg_v_i = 1'b1;
        kk_i = 8'h20;
        nn_i = 8'h10;
        ll_i = 8'h05;
        block_v_i = 1'b1;
        block_i = mkblk(0, 1);
        block_first_i = 1'b1;
        block_last_i = 1'b1;
        @(negedge clk);
        check("pri_cfg_rdy", 32'(cfg_ready_o), 32'd1);
        check("pri_blk_rdy", 32'(block_ready_o), 32'd0);
        @(posedge clk);
        #1;
        cfg_v_i = 1'b0;
        acc = 0;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = block_ready_o;
            @(posedge clk);
            #1;
        end
        block_v_i = 1'b0;
        check("pri_blk_accept", 32'(acc), 32'd1);
        wait_idle("pri");
        check("pri_count", 32'(q_dat.size() - qb), 32'd67);
        if (q_dat.size() >= qb + 3)
            check("pri_cfg", {q_cmd[qb], q_dat[qb], q_cmd[qb+1], q_dat[qb+1],
                              q_cmd[qb+2], q_dat[qb+2], 2'd0},
                  {2'd0, 8'h20, 2'd0, 8'h10, 2'd0, 8'h05, 2'd0});
        check_blk("pri", qb, 3, 0, 1, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // reset mid-block at byte 20
        send_block("rb", mkblk(0, 1), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        repeat (20) @(negedge clk);
        check("rb_byte20", {cmd_o, data_o}, {2'd2, 8'd20});
        #1 reset = 1'b1;
        #1;
        check("rb_valid_async", 32'(valid_o), 32'd0);
        check("rb_busy_async", 32'(busy_o), 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rb_cfg_rdy", 32'(cfg_ready_o), 32'd1);
        check("rb_blk_rdy", 32'(block_ready_o), 32'd1);
        @(posedge clk);
        #1;
        qb = q_dat.size();
        send_block("rb2", mkblk(8'h55, 1), 1'b1, 1'b1, 1'b0);
        wait_idle("rb2");
        check("rb2_count", 32'(q_dat.size() - qb), 32'd64);
        check_blk("rb2", qb, 0, 8'h55, 1, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
